mult_div_unit: RTL and testbench

Multi-cycle multiply/divide unit of the pipelined MIPS core, in the execute stage next to the ALU. It consumes the decoder's `mudiOp`/`isStart` control and the E-stage register operands, owns the architectural HI and LO registers, and drives `busy`. The hazard unit uses `busy` to stall later mult/div/mfhi/mflo/mthi/mtlo instructions in D. It returns HI or LO for mfhi/mflo.

---
 rtl/mult_div_unit.sv | 116 +++++++++++
 tb/tb_mult_div_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit for the E stage: owns HI/LO, holds results
// in a pending pair for a fixed busy period, then commits them.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mudiOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hiLoSel,
  output logic        busy,
  output logic [31:0] out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q;
  logic          busy_q;
  logic [31:0]   hi_q, lo_q, pHi_q, pLo_q;
  logic [CW-1:0] cnt_q;

  logic [63:0] mulS, mulU;
  logic [31:0] absA, absB, divisorU, divisorS;
  logic [31:0] qU, rU, qMag, rMag, qS, rS;
  logic        divByZero;

  // Signed divide works on magnitudes so 0x80000000 / -1 never overflows an
  // arithmetic divider; a zero divisor is swapped for 1 and the result discarded.
  always_comb begin
    mulU      = {32'd0, A} * {32'd0, B};
    mulS      = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    divByZero = (B == 32'd0);
    absA      = A[31] ? (~A + 32'd1) : A;
    absB      = B[31] ? (~B + 32'd1) : B;
    divisorU  = divByZero ? 32'd1 : B;
    divisorS  = divByZero ? 32'd1 : absB;
    qU        = A / divisorU;
    rU        = A % divisorU;
    qMag      = absA / divisorS;
    rMag      = absA % divisorS;
    qS        = (A[31] ^ B[31]) ? (~qMag + 32'd1) : qMag;
    rS        = A[31] ? (~rMag + 32'd1) : rMag;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      pHi_q   <= 32'd0;
      pLo_q   <= 32'd0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            case (mudiOp)
              3'b000, 3'b001: begin
                {pHi_q, pLo_q} <= (mudiOp == 3'b000) ? mulS : mulU;
                cnt_q   <= CW'(MULT_CYCLES);
                busy_q  <= 1'b1;
                state_q <= BUSY;
              end
              // Divide by zero re-commits the current HI/LO after the busy period.
              3'b010, 3'b011: begin
                if (divByZero) begin
                  pHi_q <= hi_q;
                  pLo_q <= lo_q;
                end else if (mudiOp == 3'b010) begin
                  pHi_q <= rS;
                  pLo_q <= qS;
                end else begin
                  pHi_q <= rU;
                  pLo_q <= qU;
                end
                cnt_q   <= CW'(DIV_CYCLES);
                busy_q  <= 1'b1;
                state_q <= BUSY;
              end
              3'b100:  hi_q <= A;
              3'b101:  lo_q <= A;
              default: ;
            endcase
          end
        end
        BUSY: begin
          if (cnt_q == CW'(1)) begin
            hi_q    <= pHi_q;
            lo_q    <= pLo_q;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;
  assign out  = hiLoSel ? hi_q : lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases plus random operations checked
// against an arithmetic reference model of HI/LO and busy length.
module tb_mult_div_unit;

  localparam int MULT_CYCLES = 5;
  localparam int DIV_CYCLES  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  mudiOp;
  logic [31:0] A, B;
  logic        hiLoSel;
  logic        busy;
  logic [31:0] out, HI, LO;

  int nChecks = 0;
  int nPass   = 0;
  logic [31:0] mHi = 32'd0;
  logic [31:0] mLo = 32'd0;

  mult_div_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
    .clk(clk), .reset(reset), .start(start), .mudiOp(mudiOp), .A(A), .B(B),
    .hiLoSel(hiLoSel), .busy(busy), .out(out), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // Reference result {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] refModel(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
    int sa, sb;
    longint la, lb, lq, lr, lp;
    longint unsigned ua, ub, uq, ur, up;
    sa = a; sb = b; la = sa; lb = sb; ua = a; ub = b;
    case (op)
      3'd0: begin lp = la * lb; return lp; end
      3'd1: begin up = ua * ub; return up; end
      3'd2: begin
        if (b == 32'd0) return {hi, lo};
        lq = la / lb; lr = la % lb;
        return {lr[31:0], lq[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return {hi, lo};
        uq = ua / ub; ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      3'd4: return {a, lo};
      3'd5: return {hi, a};
      default: return {hi, lo};
    endcase
  endfunction

  function automatic int busyCycles(input logic [2:0] op);
    if (op <= 3'd1) return MULT_CYCLES;
    if (op <= 3'd3) return DIV_CYCLES;
    return 0;
  endfunction

  // Presents one start pulse for a single edge; returns at the next negedge.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; mudiOp = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom;
  endtask

  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string tag);
    logic [63:0] exp;
    logic [31:0] expOut;
    int cycles, expCycles;
    exp = refModel(op, a, b, mHi, mLo);
    expCycles = busyCycles(op);
    applyStimulus(op, a, b);
    if (expCycles > 0) begin
      nChecks++;
      if ({HI, LO} !== {mHi, mLo})
        $display("[TB] FAIL %s_hold: HI/LO=%h expected %h", tag, {HI, LO}, {mHi, mLo});
      else nPass++;
    end
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    nChecks++;
    if (cycles !== expCycles)
      $display("[TB] FAIL %s_busy: cycles=%0d expected %0d", tag, cycles, expCycles);
    else nPass++;
    nChecks++;
    if ({HI, LO} !== exp)
      $display("[TB] FAIL %s_result: HI/LO=%h expected %h", tag, {HI, LO}, exp);
    else nPass++;
    hiLoSel = 1'($urandom);
    #1;
    expOut = hiLoSel ? exp[63:32] : exp[31:0];
    nChecks++;
    if (out !== expOut)
      $display("[TB] FAIL %s_out: out=%h expected %h", tag, out, expOut);
    else nPass++;
    mHi = exp[63:32];
    mLo = exp[31:0];
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mudiOp = 3'd0; A = 32'd0; B = 32'd0; hiLoSel = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    nChecks++;
    if ({busy, HI, LO, out} !== 97'd0)
      $display("[TB] FAIL reset_state: busy/HI/LO/out=%h expected 0", {busy, HI, LO, out});
    else nPass++;
  endtask

  task automatic test_directed();
    runOp(3'd0, 32'hFFFFFFFD, 32'd5, "mult_neg");
    runOp(3'd1, 32'hFFFFFFFF, 32'd2, "multu");
    runOp(3'd2, 32'hFFFFFFF9, 32'd2, "div_neg");
    runOp(3'd2, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
  endtask

  task automatic test_mthi_mtlo();
    applyStimulus(3'd4, 32'h12345678, 32'd0);
    start = 1'b1; mudiOp = 3'd5; A = 32'h9;
    nChecks++;
    if (HI !== 32'h12345678 || LO !== mLo || busy !== 1'b0)
      $display("[TB] FAIL mthi: HI=%h LO=%h busy=%b expected %h %h 0", HI, LO, busy, 32'h12345678, mLo);
    else nPass++;
    @(negedge clk);
    start = 1'b0; hiLoSel = 1'b1;
    #1;
    nChecks++;
    if (LO !== 32'h9 || busy !== 1'b0 || out !== 32'h12345678)
      $display("[TB] FAIL mtlo: LO=%h busy=%b out=%h expected 9 0 12345678", LO, busy, out);
    else nPass++;
    mHi = 32'h12345678; mLo = 32'h9;
  endtask

  task automatic test_div_zero();
    runOp(3'd4, 32'h11, 32'd0, "pre_hi");
    runOp(3'd5, 32'h22, 32'd0, "pre_lo");
    runOp(3'd3, 32'd7, 32'd0, "divu_zero");
    runOp(3'd2, 32'hDEADBEEF, 32'd0, "div_zero");
  endtask

  task automatic test_back_to_back();
    logic [63:0] exp;
    int cycles;
    exp = refModel(3'd2, 32'd1000, 32'd7, mHi, mLo);
    applyStimulus(3'd2, 32'd1000, 32'd7);
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      if (cycles == 3) begin
        start = 1'b1; mudiOp = 3'd0; A = 32'd3; B = 32'd4;
      end else start = 1'b0;
      @(negedge clk);
    end
    nChecks++;
    if (cycles !== DIV_CYCLES || {HI, LO} !== exp)
      $display("[TB] FAIL ignore_start: cycles=%0d HI/LO=%h expected %0d %h", cycles, {HI, LO}, DIV_CYCLES, exp);
    else nPass++;
    mHi = exp[63:32]; mLo = exp[31:0];
    exp = refModel(3'd1, 32'hABCD, 32'h1234, mHi, mLo);
    start = 1'b1; mudiOp = 3'd1; A = 32'hABCD; B = 32'h1234;
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    nChecks++;
    if (cycles !== MULT_CYCLES || {HI, LO} !== exp)
      $display("[TB] FAIL back_to_back: cycles=%0d HI/LO=%h expected %0d %h", cycles, {HI, LO}, MULT_CYCLES, exp);
    else nPass++;
    mHi = exp[63:32]; mLo = exp[31:0];
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      runOp(op, a, b, "random");
    end
  endtask

  task automatic test_reset_mid();
    logic sawBusy;
    runOp(3'd4, 32'hCAFE0001, 32'd0, "pre_hi2");
    runOp(3'd5, 32'hCAFE0002, 32'd0, "pre_lo2");
    applyStimulus(3'd0, 32'h1234567, 32'h89ABC);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    nChecks++;
    if ({busy, HI, LO, out} !== 97'd0)
      $display("[TB] FAIL reset_mid: busy/HI/LO/out=%h expected 0", {busy, HI, LO, out});
    else nPass++;
    #2 reset = 1'b0;
    sawBusy = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (busy !== 1'b0) sawBusy = 1'b1;
    end
    nChecks++;
    if (sawBusy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0)
      $display("[TB] FAIL reset_discard: sawBusy=%b HI=%h LO=%h expected 0 0 0", sawBusy, HI, LO);
    else nPass++;
    mHi = 32'd0; mLo = 32'd0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mthi_mtlo();
    test_div_zero();
    test_back_to_back();
    test_random();
    test_reset_mid();
    runOp(3'd0, 32'd6, 32'd7, "after_reset");
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
